// File: rtl/hist_pkg.sv
// Shared types and saturating arithmetic for the histogram statistics engine.
package hist_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 20;
  localparam int RUN_W_DEF = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    READ  = 2'd3
  } state_t;

  function automatic logic [32:0] sat_limit(input int width);
    return (33'd1 << width) - 33'd1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = sat_limit(width);
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic sat_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input int width);
    return ({1'b0, a} + {1'b0, b}) > sat_limit(width);
  endfunction

endpackage

// File: rtl/hist_ram_tdp.sv
// Bin storage: port A reads with one cycle of latency, port B writes.
module hist_ram_tdp
  import hist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wr_data_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A same-cycle read of the written address returns the old contents.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wr_data_b;
    rd_data_a <= mem[addr_a];
  end

endmodule

// File: rtl/hist_stat_gen.sv
// Histogram statistics engine: counts gray levels over a frame with run merging,
// then streams every bin with raw and cumulative counts while clearing it.
module hist_stat_gen
  import hist_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_vsync,
  input  logic             img_href,
  input  logic [PIX_W-1:0] img_gray,
  output logic             busy,
  output logic [PIX_W-1:0] hist_bin,
  output logic [CNT_W-1:0] hist_cnt,
  output logic [CNT_W-1:0] hist_cum,
  output logic             hist_valid,
  output logic             hist_last,
  output logic [CNT_W-1:0] frame_total,
  output logic             sat_flag,
  output logic             overrun_flag
);

  localparam int NB = 1 << PIX_W;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_t state, state_next;
  logic [PIX_W:0] cnt;
  logic vsync_q, href_q;
  logic frame_end, pix_in, drop, enter_read;

  logic             held_valid, held_valid_d;
  logic [PIX_W-1:0] held_bin, held_bin_d;
  logic [RUN_W-1:0] held_run, held_run_d;
  logic             commit;
  logic [PIX_W-1:0] commit_bin;
  logic [RUN_W-1:0] commit_run;

  logic             wb_valid;
  logic [PIX_W-1:0] wb_bin;
  logic [RUN_W-1:0] wb_run;
  logic             rd_issue, rd_v;
  logic [PIX_W-1:0] rd_bin;

  logic [CNT_W-1:0] acc_total, tot_next, wb_sum, cum_base, cum_next;
  logic             tot_sat, wb_sat, cum_sat, sat_frame;

  logic [PIX_W-1:0] ram_addr_a, ram_addr_b;
  logic [CNT_W-1:0] ram_rd, ram_wdata;
  logic             ram_we;

  assign frame_end  = vsync_q & ~img_vsync;
  assign pix_in     = img_vsync & img_href;
  assign drop       = img_href & (state != ACC);
  assign enter_read = (state == FLUSH) && (state_next == READ);

  assign tot_next = CNT_W'(sat_add(32'(acc_total), 32'd1, CNT_W));
  assign tot_sat  = sat_ovf(32'(acc_total), 32'd1, CNT_W);
  assign wb_sum   = CNT_W'(sat_add(32'(ram_rd), 32'(wb_run), CNT_W));
  assign wb_sat   = sat_ovf(32'(ram_rd), 32'(wb_run), CNT_W);
  assign cum_base = (rd_bin == '0) ? '0 : hist_cum;
  assign cum_next = CNT_W'(sat_add(32'(cum_base), 32'(ram_rd), CNT_W));
  assign cum_sat  = sat_ovf(32'(cum_base), 32'(ram_rd), CNT_W);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // INIT runs one spare cycle past the last clear so busy covers the whole pass.
  always_comb begin
    state_next = state;
    unique case (state)
      INIT:    if (cnt[PIX_W]) state_next = ACC;
      ACC:     if (frame_end) state_next = FLUSH;
      FLUSH:   if (cnt[0]) state_next = READ;
      READ:    if (&cnt[PIX_W-1:0]) state_next = ACC;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    ram_addr_a = commit_bin;
    ram_addr_b = wb_bin;
    ram_wdata  = wb_sum;
    ram_we     = 1'b0;
    rd_issue   = 1'b0;
    unique case (state)
      INIT: begin
        ram_we     = ~cnt[PIX_W];
        ram_addr_b = cnt[PIX_W-1:0];
        ram_wdata  = '0;
      end
      READ: begin
        ram_addr_a = cnt[PIX_W-1:0];
        rd_issue   = 1'b1;
      end
      default: ;
    endcase
    if (wb_valid) begin
      ram_we     = 1'b1;
      ram_addr_b = wb_bin;
      ram_wdata  = wb_sum;
    end else if (rd_v) begin
      ram_we     = 1'b1;
      ram_addr_b = rd_bin;
      ram_wdata  = '0;
    end
  end

  // Run merge: a commit hands (bin, run) to the read-modify-write pipeline.
  always_comb begin
    commit       = 1'b0;
    commit_bin   = held_bin;
    commit_run   = held_run;
    held_valid_d = held_valid;
    held_bin_d   = held_bin;
    held_run_d   = held_run;
    if (state == ACC) begin
      if (frame_end) begin
        commit       = held_valid;
        held_valid_d = 1'b0;
      end else if (pix_in) begin
        if (held_valid && (img_gray == held_bin)) begin
          if (held_run == RUN_MAX - 1'b1) begin
            commit       = 1'b1;
            commit_run   = RUN_MAX;
            held_valid_d = 1'b0;
          end else begin
            held_run_d = held_run + 1'b1;
          end
        end else begin
          commit       = held_valid;
          held_valid_d = 1'b1;
          held_bin_d   = img_gray;
          held_run_d   = RUN_W'(1);
        end
      end else if (href_q && !img_href) begin
        commit       = held_valid;
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; vsync_q <= 1'b0; href_q <= 1'b0;
      held_valid <= 1'b0; held_bin <= '0; held_run <= '0;
      wb_valid <= 1'b0; wb_bin <= '0; wb_run <= '0;
      rd_v <= 1'b0; rd_bin <= '0;
      acc_total <= '0; sat_frame <= 1'b0;
      busy <= 1'b0; hist_bin <= '0; hist_cnt <= '0; hist_cum <= '0;
      hist_valid <= 1'b0; hist_last <= 1'b0; frame_total <= '0;
      sat_flag <= 1'b0; overrun_flag <= 1'b0;
    end else begin
      cnt        <= (state_next != state) ? '0 : cnt + 1'b1;
      vsync_q    <= img_vsync;
      href_q     <= img_href;
      held_valid <= held_valid_d;
      held_bin   <= held_bin_d;
      held_run   <= held_run_d;
      wb_valid   <= commit;
      wb_bin     <= commit_bin;
      wb_run     <= commit_run;
      rd_v       <= rd_issue;
      rd_bin     <= cnt[PIX_W-1:0];
      busy       <= (state_next != ACC);

      if ((state == ACC) && pix_in) acc_total <= tot_next;
      if (enter_read) begin
        frame_total <= acc_total;
        acc_total   <= '0;
      end

      hist_valid <= rd_v;
      hist_last  <= rd_v & (&rd_bin);
      if (rd_v) begin
        hist_bin <= rd_bin;
        hist_cnt <= ram_rd;
        hist_cum <= cum_next;
      end

      // The readout reports saturation seen during its own frame only.
      if (enter_read) begin
        sat_flag     <= sat_frame | (wb_valid & wb_sat);
        sat_frame    <= 1'b0;
        overrun_flag <= drop;
      end else begin
        if ((wb_valid && wb_sat) || ((state == ACC) && pix_in && tot_sat)) begin
          sat_flag  <= 1'b1;
          sat_frame <= 1'b1;
        end
        if (rd_v && cum_sat) sat_flag <= 1'b1;
        if (drop) overrun_flag <= 1'b1;
      end
    end
  end

  hist_ram_tdp #(
    .ADDR_W(PIX_W),
    .DATA_W(CNT_W),
    .DEPTH (NB)
  ) u_ram (
    .clk      (clk),
    .addr_a   (ram_addr_a),
    .rd_data_a(ram_rd),
    .we_b     (ram_we),
    .addr_b   (ram_addr_b),
    .wr_data_b(ram_wdata)
  );

endmodule
